// File: rtl/apb_pkg.sv
// apb_pkg: shared constants for the APB master controller.
//   ST_*        : FSM state encoding (IDLE / SETUP / ACCESS)
//   ADDR_W_DEF  : default APB address width
//   DATA_W_DEF  : default APB data width
package apb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SETUP  = 2'b01;
  localparam logic [1:0] ST_ACCESS = 2'b10;

endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: wait-state counter for one APB transfer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : reset count to 0 (priority over inc)
//   inc        : count one more wait state
//   expired    : count has reached TIMEOUT-1; constant 0 when TIMEOUT = 0
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_in;
    assign unused_in = ^{clk, rst_n, clr, inc};
    assign expired   = 1'b0;
  end else begin : g_on
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (clr) begin
        cnt_q <= '0;
      end else if (inc) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: valid/ready command stream to APB3/APB4 master.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   cmd_*             : command stream (valid/ready), write flag, addr, wdata, strobes
//   rsp_*             : one-cycle response pulse with read data, error, timeout flag
//   psel_o..pstrb_o   : APB request outputs
//   pready_i..pslverr_i : APB slave response inputs
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_strb_i,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                rsp_timeout_o,
  output logic                psel_o,
  output logic                penable_o,
  output logic [ADDR_W-1:0]   paddr_o,
  output logic                pwrite_o,
  output logic [DATA_W-1:0]   pwdata_o,
  output logic [DATA_W/8-1:0] pstrb_o,
  input  logic                pready_i,
  input  logic [DATA_W-1:0]   prdata_i,
  input  logic                pslverr_i
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [1:0]        state_q, state_d;
  logic              ready_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [STRB_W-1:0] pstrb_q;
  logic              rsp_valid_q, rsp_err_q, rsp_timeout_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic handshake, in_setup, in_access, done, timeout_hit, expired;

  assign in_setup    = (state_q == ST_SETUP);
  assign in_access   = (state_q == ST_ACCESS);
  assign handshake   = cmd_valid_i & ready_q;
  assign done        = in_access & pready_i;
  // pready_i on the terminal count wins, so expiry only counts with pready_i low
  assign timeout_hit = in_access & ~pready_i & expired;

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (in_setup),
    .inc     (in_access & ~pready_i),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (handshake) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (pready_i || timeout_hit) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ready is registered so it stays low while rst_n is asserted and rises
  // on the first clock after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else if (handshake) begin
      pwrite_q <= cmd_write_i;
      paddr_q  <= cmd_addr_i;
      pwdata_q <= cmd_wdata_i;
      pstrb_q  <= cmd_write_i ? cmd_strb_i : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      rsp_valid_q   <= done | timeout_hit;
      rsp_err_q     <= done ? pslverr_i : timeout_hit;
      rsp_timeout_q <= timeout_hit;
      rsp_rdata_q   <= (done && !pwrite_q) ? prdata_i : '0;
    end
  end

  assign cmd_ready_o   = ready_q;
  assign psel_o        = in_setup | in_access;
  assign penable_o     = in_access;
  assign pwrite_o      = pwrite_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign pstrb_o       = pstrb_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign rsp_rdata_o   = rsp_rdata_q;

endmodule
